matrix_row_driver: RTL

//  Row-side driver for the LED matrix. It pairs with the one-hot column ring counter.
//  - Accepts a full frame bitmap over a valid/ready handshake into a double buffer.
//  - Paces the column scan by issuing a one-cycle col_step strobe (column selector enable).
//  - Drives the row lines with the active column's pattern, blanking around each column change.

---
 rtl/matrix_pkg.sv | 33 +++
 rtl/matrix_row_driver_buffer.sv | 38 +++
 rtl/matrix_row_driver.sv | 133 +++++++++++++
 3 files changed

// File: rtl/matrix_pkg.sv
// Shared definitions for the LED matrix row driver: default geometry,
// scan phase encoding and one-hot column helpers.
package matrix_pkg;

   localparam int MATRIX_COLS = 3;
   localparam int MATRIX_ROWS = 7;

   // Widest column vector the helper functions accept; narrower vectors are zero-extended.
   localparam int MAX_COLS = 32;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_SHOW  = 1'b1
   } phase_t;

   // Position of the set bit in a one-hot vector (highest set bit if several are set).
   function automatic int onehot_to_index(input logic [MAX_COLS-1:0] vec);
      int idx;
      idx = 0;
      for (int i = 0; i < MAX_COLS; i++) begin
         if (vec[i]) begin
            idx = i;
         end
      end
      return idx;
   endfunction

   // True when exactly one bit is set.
   function automatic logic is_onehot(input logic [MAX_COLS-1:0] vec);
      return (vec != '0) && ((vec & (vec - MAX_COLS'(1))) == '0);
   endfunction

endpackage

// File: rtl/matrix_row_driver_buffer.sv
// Double frame buffer: a shadow register filled over a valid/ready handshake
// and an active register that the scan reads, copied from the shadow on swap.
module frame_double_buffer
   import matrix_pkg::*;
#(
   parameter int WIDTH = MATRIX_COLS * MATRIX_ROWS
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             swap,
   output logic [WIDTH-1:0] active
);

   logic [WIDTH-1:0] shadow;
   logic             shadow_full;

   // Ready is simply the inverse of a register, so it stays glitch-free and drops the cycle after a transfer.
   assign in_ready = !shadow_full;

   // Accept a frame into the empty shadow, or hand a full shadow over to the active side on swap.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         shadow      <= '0;
         shadow_full <= 1'b0;
         active      <= '0;
      end else if (in_valid && in_ready) begin
         shadow      <= in_data;
         shadow_full <= 1'b1;
      end else if (swap && shadow_full) begin
         active      <= shadow;
         shadow_full <= 1'b0;
      end
   end

endmodule

// File: rtl/matrix_row_driver.sv
// Row-side driver for the LED matrix: paces the column ring counter with a
// col_step strobe, blanks the rows around each column change and drives the
// active column's pattern from a double-buffered frame.
module matrix_row_driver
   import matrix_pkg::*;
#(
   parameter int COLS  = MATRIX_COLS,
   parameter int ROWS  = MATRIX_ROWS,
   parameter int DWELL = 1000,
   parameter int BLANK = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [COLS-1:0]      col,
   output logic                 col_step,
   output logic [ROWS-1:0]      row,
   input  logic [COLS*ROWS-1:0] frame_data,
   input  logic                 frame_valid,
   output logic                 frame_ready,
   output logic                 col_error
);

   localparam int PHASE_MAX = (DWELL > BLANK) ? DWELL : BLANK;
   localparam int CNT_W     = $clog2(PHASE_MAX + 1);
   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);

   phase_t                state;
   phase_t                state_next;
   logic [CNT_W-1:0]      cnt;
   logic [CNT_W-1:0]      cnt_next;
   logic [COLS*ROWS-1:0]  active;
   logic                  col_valid;
   int                    col_idx;
   logic [ROWS-1:0]       col_pattern;
   logic                  swap;

   assign col_valid = is_onehot(MAX_COLS'(col));
   assign col_idx   = onehot_to_index(MAX_COLS'(col));

   // Swapping only at the last column's step keeps a frame from tearing; a stopped scan swaps at once.
   assign swap = enable ? (col_step && col[COLS-1]) : 1'b1;

   frame_double_buffer #(
      .WIDTH(COLS * ROWS)
   ) u_buffer (
      .clock    (clock),
      .reset    (reset),
      .in_data  (frame_data),
      .in_valid (frame_valid),
      .in_ready (frame_ready),
      .swap     (swap),
      .active   (active)
   );

   // Select the stored pattern of the currently lit column.
   always_comb begin
      col_pattern = '0;
      for (int c = 0; c < COLS; c++) begin
         if (col_idx == c) begin
            col_pattern = active[c*ROWS +: ROWS];
         end
      end
   end

   // Phase state and dwell counter registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= ST_BLANK;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Blank for BLANK cycles, show for DWELL cycles, strobe col_step on the last shown cycle.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      col_step   = 1'b0;
      if (!enable) begin
         state_next = ST_BLANK;
         cnt_next   = '0;
      end else begin
         case (state)
            ST_BLANK: begin
               if (cnt == BLANK_LAST) begin
                  state_next = ST_SHOW;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt + 1'b1;
               end
            end
            ST_SHOW: begin
               if (cnt == DWELL_LAST) begin
                  col_step   = 1'b1;
                  state_next = ST_BLANK;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt + 1'b1;
               end
            end
            default: begin
               state_next = ST_BLANK;
               cnt_next   = '0;
            end
         endcase
      end
   end

   // Register the row drive; dark unless showing a valid one-hot column.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         row <= '0;
      end else if (enable && (state == ST_SHOW) && col_valid) begin
         row <= col_pattern;
      end else begin
         row <= '0;
      end
   end

   // Latch a sticky error whenever the column selector is not one-hot while lit.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         col_error <= 1'b0;
      end else if (enable && (state == ST_SHOW) && !col_valid) begin
         col_error <= 1'b1;
      end
   end

endmodule
